majority_vote_ctrl: RTL and testbench

Sequencer that collects three single-bit votes serially over a val/rdy stream and presents them to a majority (pair/triple) detector. It then holds the decision on an output val/rdy stream until a consumer takes it. It sits between a serial ballot source and downstream logic that needs one registered, handshaked majority decision per three votes. It also keeps a wrap-around count of delivered decisions.

---
 rtl/majority_vote_pkg.sv | 15 +
 rtl/majority3.sv | 12 +
 rtl/majority_vote_ctrl.sv | 106 ++++++++++
 tb/tb_majority_vote_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/majority_vote_pkg.sv
// Shared types and defaults for the serial majority-vote sequencer.
package majority_vote_pkg;

  // Default width of the delivered-decision counter.
  localparam int unsigned CntWDefault = 8;

  // Ballot sequencer states: collecting vote 0/1/2, then holding the result.
  typedef enum logic [1:0] {
    S_V0,
    S_V1,
    S_V2,
    S_RES
  } state_e;

endpackage

// File: rtl/majority3.sv
// Three-input pair/triple (majority) detector, written as plain gates so that
// an unknown input is masked whenever the other two inputs agree.
module majority3 (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic out
);

  assign out = (in0 & in1) | (in0 & in2) | (in1 & in2);

endmodule

// File: rtl/majority_vote_ctrl.sv
// Collects three serial votes, presents a registered majority decision on a
// val/rdy stream, and counts decisions taken by the consumer.
module majority_vote_ctrl
  import majority_vote_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vote_val,
  output logic             vote_rdy,
  input  logic             vote_bit,
  input  logic             abort,
  output logic             res_val,
  input  logic             res_rdy,
  output logic             res_out,
  output logic             res_unan,
  output logic [CNT_W-1:0] count
);

  state_e           state_q, state_d;
  logic [2:0]       votes_q, votes_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             vote_fire;
  logic             maj;
  logic             unan;

  // Ready is state-decoded; reset gates it so nothing is offered mid-reset.
  assign vote_rdy  = rst_n & (state_q != S_RES);
  assign vote_fire = vote_val & (state_q != S_RES);

  // Next-state, vote capture and counter update.
  always_comb begin
    state_d = state_q;
    votes_d = votes_q;
    count_d = count_q;
    unique case (state_q)
      S_V0: begin
        // Abort here only clears the ballot; a same-cycle vote still lands in v0.
        if (abort) votes_d = 3'b000;
        if (vote_fire) begin
          votes_d[0] = vote_bit;
          state_d    = S_V1;
        end
      end
      S_V1: begin
        if (abort) begin
          votes_d = 3'b000;
          state_d = S_V0;
        end else if (vote_fire) begin
          votes_d[1] = vote_bit;
          state_d    = S_V2;
        end
      end
      S_V2: begin
        if (abort) begin
          votes_d = 3'b000;
          state_d = S_V0;
        end else if (vote_fire) begin
          votes_d[2] = vote_bit;
          state_d    = S_RES;
        end
      end
      S_RES: begin
        // Decision is committed: abort is ignored, only the consumer releases it.
        if (res_rdy) begin
          state_d = S_V0;
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = S_V0;
    endcase
  end

  // State, vote and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_V0;
      votes_q <= 3'b000;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      votes_q <= votes_d;
      count_q <= count_d;
    end
  end

  majority3 u_majority3 (
    .in0 (votes_q[0]),
    .in1 (votes_q[1]),
    .in2 (votes_q[2]),
    .out (maj)
  );

  // Unanimity; the xor-with-itself term is logically zero but carries an
  // unknown from any vote so the flag never hides an X ballot.
  assign unan = ((votes_q[0] ~^ votes_q[1]) & (votes_q[1] ~^ votes_q[2]))
                ^ ((^votes_q) ^ (^votes_q));

  // Output decode: decision fields are forced low outside the result state.
  assign res_val  = (state_q == S_RES);
  assign res_out  = res_val & maj;
  assign res_unan = res_val & unan;
  assign count    = count_q;

endmodule

// File: tb/tb_majority_vote_ctrl.sv
// Directed bench for majority_vote_ctrl; a second instance with a 2-bit
// counter shares all stimulus to exercise counter wrap.
module tb_majority_vote_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vote_val;
  logic       vote_bit;
  logic       abort;
  logic       res_rdy;
  logic       vote_rdy, res_val, res_out, res_unan;
  logic [7:0] count8;
  logic       vote_rdy2, res_val2, res_out2, res_unan2;
  logic [1:0] count2;

  int n_checks = 0;
  int n_pass   = 0;
  int model_cnt = 0;

  logic [7:0] maj_tbl  = 8'b1110_1000;  // indexed by {v0,v1,v2}
  logic [7:0] unan_tbl = 8'b1000_0001;
  logic       xv;
  logic       exp_u;

  always #5 clk = ~clk;

  majority_vote_ctrl #(.CNT_W(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vote_val (vote_val),
    .vote_rdy (vote_rdy),
    .vote_bit (vote_bit),
    .abort    (abort),
    .res_val  (res_val),
    .res_rdy  (res_rdy),
    .res_out  (res_out),
    .res_unan (res_unan),
    .count    (count8)
  );

  majority_vote_ctrl #(.CNT_W(2)) u_dut_w2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .vote_val (vote_val),
    .vote_rdy (vote_rdy2),
    .vote_bit (vote_bit),
    .abort    (abort),
    .res_val  (res_val2),
    .res_rdy  (res_rdy),
    .res_out  (res_out2),
    .res_unan (res_unan2),
    .count    (count2)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %b expected %b", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag);
    check({tag, "_cnt8"}, count8, 8'(model_cnt % 256));
    check({tag, "_cnt2"}, 8'(count2), 8'(model_cnt % 4));
  endtask

  task automatic send_votes(input logic a, input logic b, input logic c);
    logic [2:0] v;
    v = {a, b, c};
    for (int i = 2; i >= 0; i--) begin
      vote_val = 1'b1;
      vote_bit = v[i];
      tick();
    end
    vote_val = 1'b0;
    vote_bit = 1'b0;
  endtask

  // Full ballot: three votes, check the held decision, then hand it off.
  task automatic ballot(input logic a, input logic b, input logic c,
                        input logic e_out, input logic e_unan, input string tag);
    send_votes(a, b, c);
    check({tag, "_val"},  8'(res_val),  8'd1);
    check({tag, "_out"},  8'(res_out),  8'(e_out));
    check({tag, "_unan"}, 8'(res_unan), 8'(e_unan));
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    model_cnt++;
    check({tag, "_val_after"}, 8'(res_val), 8'd0);
    check({tag, "_rdy_after"}, 8'(vote_rdy), 8'd1);
    check_count(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    vote_val = 1'b0;
    vote_bit = 1'b0;
    abort    = 1'b0;
    res_rdy  = 1'b0;
    tick();
    tick();
    check("rst_vote_rdy", 8'(vote_rdy), 8'd0);
    check("rst_res_val",  8'(res_val),  8'd0);
    check("rst_res_out",  8'(res_out),  8'd0);
    check("rst_res_unan", 8'(res_unan), 8'd0);
    check_count("rst");
    rst_n = 1'b1;
    #1;
    check("rel_vote_rdy", 8'(vote_rdy), 8'd1);

    // Basic: 0,1,1 back-to-back with the consumer always ready.
    res_rdy = 1'b1;
    send_votes(1'b0, 1'b1, 1'b1);
    check("basic_val",  8'(res_val),  8'd1);
    check("basic_out",  8'(res_out),  8'd1);
    check("basic_unan", 8'(res_unan), 8'd0);
    check("basic_rdy",  8'(vote_rdy), 8'd0);
    tick();
    res_rdy = 1'b0;
    model_cnt++;
    check("basic_val_after", 8'(res_val), 8'd0);
    check_count("basic");

    // Exhaustive over all eight patterns.
    for (int p = 0; p < 8; p++) begin
      logic [2:0] pv;
      pv = 3'(p);
      ballot(pv[2], pv[1], pv[0], maj_tbl[p], unan_tbl[p], $sformatf("exh%0d", p));
    end

    // Backpressure: decision must hold while the consumer stalls.
    send_votes(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_val", i),  8'(res_val),  8'd1);
      check($sformatf("bp%0d_out", i),  8'(res_out),  8'd1);
      check($sformatf("bp%0d_unan", i), 8'(res_unan), 8'd1);
      check($sformatf("bp%0d_rdy", i),  8'(vote_rdy), 8'd0);
      abort = (i == 2);  // ignored in the result state
      tick();
    end
    abort   = 1'b0;
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    model_cnt++;
    check("bp_rdy_after", 8'(vote_rdy), 8'd1);
    check("bp_val_after", 8'(res_val),  8'd0);
    check_count("bp");

    // Abort in S_V2 with a same-cycle vote: vote dropped, back to S_V0.
    vote_val = 1'b1;
    vote_bit = 1'b1;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    vote_val = 1'b0;
    check("abort_val", 8'(res_val),  8'd0);
    check("abort_rdy", 8'(vote_rdy), 8'd1);
    ballot(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "post_abort");

    // Abort in S_V0 with a vote: the vote is still taken as v0.
    abort    = 1'b1;
    vote_val = 1'b1;
    vote_bit = 1'b1;
    tick();
    abort = 1'b0;
    vote_bit = 1'b1;
    tick();
    vote_bit = 1'b0;
    tick();
    vote_val = 1'b0;
    check("abort_v0_val", 8'(res_val), 8'd1);
    check("abort_v0_out", 8'(res_out), 8'd1);
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    model_cnt++;
    check_count("abort_v0");

    // Reset while holding a decision.
    send_votes(1'b1, 1'b1, 1'b1);
    check("prerst_val", 8'(res_val), 8'd1);
    rst_n = 1'b0;
    tick();
    model_cnt = 0;
    check("midrst_val", 8'(res_val),  8'd0);
    check("midrst_rdy", 8'(vote_rdy), 8'd0);
    check_count("midrst");
    rst_n = 1'b1;
    #1;
    check("midrst_rel_rdy", 8'(vote_rdy), 8'd1);
    tick();
    check("midrst_rel_val", 8'(res_val), 8'd0);

    // Wrap: five decisions on the 2-bit counter leave it at 1.
    ballot(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "wrap0");
    ballot(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "wrap1");
    ballot(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "wrap2");
    ballot(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "wrap3");
    ballot(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "wrap4");
    check("wrap_cnt2_is1", 8'(count2), 8'd1);
    check("wrap_cnt8_is5", count8,     8'd5);

    // Unknown vote: masked by two agreeing votes, visible otherwise.
    xv = 1'bx;
    exp_u = (xv === 1'b1) ? 1'b1 : ((xv === 1'b0) ? 1'b0 : 1'bx);
    send_votes(xv, 1'b1, 1'b1);
    check("x11_out",  8'(res_out),  8'd1);
    check("x11_unan", 8'(res_unan), 8'(exp_u));
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    send_votes(xv, 1'b1, 1'b0);
    check("x10_val", 8'(res_val), 8'd1);
    check("x10_out", 8'(res_out), 8'(xv));
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    check("x_done_rdy", 8'(vote_rdy), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
